// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared display geometry, memory widths and data types for the scanline
// renderers (tile_drawer, sprite_drawer).
//   tam_entry_t : one tile attribute map entry (tile index, hflip, vflip)
//   pixel_row_t : one 16-pixel row of palette indices, pixel 0 in [7:0]
//   state_t     : tile_drawer FSM states
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int DISPLAY_WIDTH  = 640;
    localparam int DISPLAY_HEIGHT = 480;
    localparam int TILE_SIZE      = 16;
    localparam int MAP_COLS       = DISPLAY_WIDTH / TILE_SIZE;
    localparam int MAP_ROWS       = DISPLAY_HEIGHT / TILE_SIZE;
    localparam int TAM_ADDR_SIZE  = 11;
    localparam int VRAM_ADDR_SIZE = 12;
    localparam int COLOR_DEPTH    = 8;

    typedef struct packed {
        logic [5:0] reserved;
        logic       vflip;
        logic       hflip;
        logic [7:0] tile_index;
    } tam_entry_t;

    typedef logic [TILE_SIZE-1:0][COLOR_DEPTH-1:0] pixel_row_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAM_RD,
        ST_TAM_WT,
        ST_VRAM_RD,
        ST_VRAM_WT,
        ST_STORE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/tile_drawer_if.sv
// -----------------------------------------------------------------------------
// tile_drawer_if
// Memory-side bus of the background renderer.
//   tam_a / tam_d   : tile attribute map read port (1-cycle read latency)
//   vram_a / vram_d : tile VRAM read port, one 16-pixel row per word
//   lb_we / lb_addr / lb_data : next-line buffer block write port
// master = renderer, slave = memories / line buffer.
// -----------------------------------------------------------------------------
interface tile_drawer_if;
    import display_pkg::*;

    logic [TAM_ADDR_SIZE-1:0]  tam_a;
    logic [15:0]               tam_d;
    logic [VRAM_ADDR_SIZE-1:0] vram_a;
    pixel_row_t                vram_d;
    logic                      lb_we;
    logic [5:0]                lb_addr;
    pixel_row_t                lb_data;

    modport master (
        output tam_a, vram_a, lb_we, lb_addr, lb_data,
        input  tam_d, vram_d
    );

    modport slave (
        input  tam_a, vram_a, lb_we, lb_addr, lb_data,
        output tam_d, vram_d
    );

endinterface

// File: rtl/tile_drawer_row_align.sv
// -----------------------------------------------------------------------------
// row_align (combinational)
// Applies the horizontal flip to a fetched tile row and funnel-shifts the
// pair {current, previous} right by the fine scroll so the output block
// starts at the first visible pixel.
//   i_word    : raw VRAM row of the current fetch
//   i_hflip   : reverse pixel order of i_word
//   i_prev    : already-flipped row of the previous fetch
//   i_fine    : fine scroll, 0..15 pixels
//   o_word    : i_word after hflip (becomes i_prev of the next fetch)
//   o_aligned : low 16 pixels of ({o_word, i_prev} >> 8*i_fine)
// -----------------------------------------------------------------------------
module row_align
    import display_pkg::*;
(
    input  pixel_row_t i_word,
    input  logic       i_hflip,
    input  pixel_row_t i_prev,
    input  logic [3:0] i_fine,
    output pixel_row_t o_word,
    output pixel_row_t o_aligned
);

    localparam int ROW_BITS = TILE_SIZE * COLOR_DEPTH;

    logic [2*ROW_BITS-1:0] w_pair;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        o_word = i_word;
        if (i_hflip) begin
            for (int i = 0; i < TILE_SIZE; i++) begin
                o_word[i] = i_word[TILE_SIZE-1-i];
            end
        end
    end

    // The previous row holds the leftmost pixels, so it sits in the low half.
    assign w_pair    = {o_word, i_prev};
    assign o_aligned = ROW_BITS'(w_pair >> {i_fine, 3'b000});

endmodule

// File: rtl/tile_drawer.sv
// -----------------------------------------------------------------------------
// tile_drawer
// Background-layer renderer for one scanline. On start it walks the tile
// attribute map and tile VRAM for the requested line and writes 40 blocks of
// 16 palette indices into the next-line buffer, one block every 5 cycles.
//   clk, btn_rst : pixel clock, asynchronous active-low reset
//   start        : one-cycle render request, honoured only when idle
//   line_number  : screen line to render (>= 480 finishes without any access)
//   scroll_x/y   : background scroll in pixels
//   busy, done   : render in progress / one-cycle completion pulse
//   bus          : TAM, VRAM and line-buffer ports (tile_drawer_if.master)
// -----------------------------------------------------------------------------
module tile_drawer
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        btn_rst,
    input  logic        start,
    input  logic [9:0]  line_number,
    input  logic [9:0]  scroll_x,
    input  logic [8:0]  scroll_y,
    output logic        busy,
    output logic        done,
    tile_drawer_if.master bus
);

    localparam int COL_W = $clog2(MAP_COLS);
    localparam int ROW_W = $clog2(MAP_ROWS);
    localparam logic [5:0] LAST_K = 6'(MAP_COLS);

    state_t r_state;
    state_t w_state_next;

    logic                      r_busy;
    logic                      r_done;
    logic                      r_lb_we;
    logic [5:0]                r_lb_addr;
    pixel_row_t                r_lb_data;
    logic [TAM_ADDR_SIZE-1:0]  r_tam_a;
    logic [TAM_ADDR_SIZE-1:0]  r_tam_base;
    logic [VRAM_ADDR_SIZE-1:0] r_vram_a;
    logic [5:0]                r_k;
    logic [COL_W-1:0]          r_col;
    logic [3:0]                r_row;
    logic [3:0]                r_fine;
    logic                      r_hflip;
    pixel_row_t                r_prev;

    logic [9:0]                w_sx;
    logic [8:0]                w_sy;
    logic [9:0]                w_ey_sum;
    logic [9:0]                w_ey;
    logic                      w_line_ok;
    logic [ROW_W-1:0]          w_tile_row;
    logic [COL_W-1:0]          w_coarse;
    logic [TAM_ADDR_SIZE-1:0]  w_tam_base;
    logic [COL_W-1:0]          w_col_next;
    tam_entry_t                w_entry;
    logic [3:0]                w_r;
    pixel_row_t                w_word;
    pixel_row_t                w_aligned;
    logic                      w_unused;

    // ---------------- start-time decode ----------------
    // Scroll inputs never exceed twice the screen size, so one conditional
    // subtraction brings them into range.
    assign w_sx = (scroll_x >= 10'(DISPLAY_WIDTH))  ? scroll_x - 10'(DISPLAY_WIDTH)  : scroll_x;
    assign w_sy = (scroll_y >= 9'(DISPLAY_HEIGHT))  ? scroll_y - 9'(DISPLAY_HEIGHT)  : scroll_y;

    // Both addends are below 480 for a valid line, so the sum stays under 960.
    assign w_ey_sum   = line_number + {1'b0, w_sy};
    assign w_ey       = (w_ey_sum >= 10'(DISPLAY_HEIGHT)) ? w_ey_sum - 10'(DISPLAY_HEIGHT) : w_ey_sum;
    assign w_line_ok  = (line_number < 10'(DISPLAY_HEIGHT));
    assign w_tile_row = w_ey[8:4];
    assign w_coarse   = w_sx[9:4];
    assign w_tam_base = TAM_ADDR_SIZE'(w_tile_row) * TAM_ADDR_SIZE'(MAP_COLS);

    // ---------------- fetch datapath ----------------
    assign w_col_next = (r_col == COL_W'(MAP_COLS - 1)) ? '0 : r_col + 1'b1;

    assign w_entry = bus.tam_d;
    assign w_r     = w_entry.vflip ? ~r_row : r_row;

    // Reserved attribute bits and the always-zero top bit of ey are ignored.
    assign w_unused = ^{w_entry.reserved, w_ey[9]};

    row_align u_row_align (
        .i_word    (bus.vram_d),
        .i_hflip   (r_hflip),
        .i_prev    (r_prev),
        .i_fine    (r_fine),
        .o_word    (w_word),
        .o_aligned (w_aligned)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge btn_rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples values from before the edge, independent of block order.
        if (!btn_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_next = w_line_ok ? ST_TAM_RD : ST_DONE;
            ST_TAM_RD:  w_state_next = ST_TAM_WT;
            ST_TAM_WT:  w_state_next = ST_VRAM_RD;
            ST_VRAM_RD: w_state_next = ST_VRAM_WT;
            ST_VRAM_WT: w_state_next = ST_STORE;
            ST_STORE:   w_state_next = (r_k == LAST_K) ? ST_DONE : ST_TAM_RD;
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- registered outputs and datapath ----------------
    // Each address is loaded on the edge entering the state that presents it
    // to the synchronous memory, so read data is valid in the following
    // wait state.
    always_ff @(posedge clk or negedge btn_rst) begin
        if (!btn_rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lb_we    <= 1'b0;
            r_lb_addr  <= '0;
            r_lb_data  <= '0;
            r_tam_a    <= '0;
            r_tam_base <= '0;
            r_vram_a   <= '0;
            r_k        <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_fine     <= '0;
            r_hflip    <= 1'b0;
            r_prev     <= '0;
        end else begin
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (w_state_next == ST_DONE);
            // Fetch 0 only primes r_prev; block writes start with fetch 1.
            r_lb_we <= (r_state == ST_VRAM_WT) && (r_k != '0);

            case (r_state)
                ST_IDLE: begin
                    if (start && w_line_ok) begin
                        r_k        <= '0;
                        r_col      <= w_coarse;
                        r_tam_base <= w_tam_base;
                        r_tam_a    <= w_tam_base + TAM_ADDR_SIZE'(w_coarse);
                        r_row      <= w_ey[3:0];
                        r_fine     <= w_sx[3:0];
                    end
                end
                ST_TAM_WT: begin
                    r_hflip  <= w_entry.hflip;
                    r_vram_a <= {w_entry.tile_index, w_r};
                end
                ST_VRAM_WT: begin
                    r_prev <= w_word;
                    if (r_k != '0) begin
                        r_lb_data <= w_aligned;
                        r_lb_addr <= r_k - 6'd1;
                    end
                end
                ST_STORE: begin
                    if (r_k != LAST_K) begin
                        r_k     <= r_k + 6'd1;
                        r_col   <= w_col_next;
                        r_tam_a <= r_tam_base + TAM_ADDR_SIZE'(w_col_next);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign bus.tam_a   = r_tam_a;
    assign bus.vram_a  = r_vram_a;
    assign bus.lb_we   = r_lb_we;
    assign bus.lb_addr = r_lb_addr;
    assign bus.lb_data = r_lb_data;

endmodule

// File: doc/tile_drawer.md
# tile_drawer

Background-layer renderer for one scanline. On a `start` pulse it walks the tile attribute map (TAM) and tile VRAM for the requested line and writes 40 blocks of 16 palette indices into the next-line buffer. `sprite_drawer` then overlays sprites on that buffer. It sits between the TAM/TILE memories and the line buffer, and runs once per line during the preceding line period.

## Interface
Parameters:
- `DISPLAY_WIDTH`, 640: visible pixels per line
- `DISPLAY_HEIGHT`, 480: visible lines
- `TILE_SIZE`, 16: tile edge in pixels; fixed by the 128-bit VRAM word
- `MAP_COLS`, 40: DISPLAY_WIDTH/TILE_SIZE
- `MAP_ROWS`, 30: DISPLAY_HEIGHT/TILE_SIZE
- `TAM_ADDR_SIZE`, 11: TAM read address width; 1200 entries
- `VRAM_ADDR_SIZE`, 12: tile VRAM read address width
- `COLOR_DEPTH`, 8: palette index width

Ports:
- `clk`, in, 1: pixel clock
- `btn_rst`, in, 1: asynchronous active-low reset
- `start`, in, 1: one-cycle request to render `line_number`
- `line_number`, in, 10: screen line to render
- `scroll_x`, in, 10: horizontal scroll in pixels
- `scroll_y`, in, 9: vertical scroll in pixels
- `busy`, out, 1: render in progress
- `done`, out, 1: one-cycle pulse when the line is complete
- `tam_a`, out, TAM_ADDR_SIZE: TAM read address
- `tam_d`, in, 16: TAM entry; 1-cycle synchronous read latency
- `vram_a`, out, VRAM_ADDR_SIZE: tile VRAM read address
- `vram_d`, in, 128: 16 pixels × 8 b, pixel 0 in [7:0]; 1-cycle latency
- `lb_we`, out, 1: line-buffer block write strobe
- `lb_addr`, out, 6: block index 0..39
- `lb_data`, out, 128: 16 pixels, leftmost pixel in [7:0]

## Operation
- TAM entry format: [7:0] tile index, [8] hflip, [9] vflip, [15:10] reserved and ignored.
- At `start` in IDLE, the block latches its inputs:
  - `scroll_x` values ≥640 and `scroll_y` values ≥480 are reduced by one subtraction.
  - ey = (line_number + scroll_y) mod 480. tile_row = ey/16. row = ey%16.
  - coarse = scroll_x/16. fine = scroll_x%16.
- Fetch loop, k = 0..40 (41 fetches):
  - col = (coarse + k) mod 40.
  - tam_a = tile_row*40 + col.
  - r = vflip ? 15−row : row.
  - vram_a = {tile_index, r[3:0]}.
  - The word is pixel-reversed if hflip. The result is W_k.
- Output: after fetch k≥1, the block writes block c = k−1.
  - lb_data = low 128 bits of ({W_k, W_{k−1}} >> 8·fine).
  - lb_addr = c.
- Pixel value 0 is written unchanged (transparent/backdrop, palette entry 0).
- `line_number` ≥ DISPLAY_HEIGHT: no reads and no writes. `done` pulses on the cycle after `start`.
- `start` while busy is ignored. There is no queueing.
- States:
  - IDLE → TAM_RD → TAM_WT → VRAM_RD → VRAM_WT → STORE.
  - From STORE, go back to TAM_RD while k<40. After k=40, go to DONE.
  - DONE → IDLE.
- Reset (any time, including mid-line):
  - state IDLE; busy, done and lb_we 0; tam_a, vram_a, lb_addr and lb_data 0; k 0.
  - A line that is reset mid-render is abandoned. No further writes occur.

## Timing
- Cycle 0 is the edge that samples `start`. The FSM is in TAM_RD on cycle 1.
- Each fetch takes 5 cycles, so fetch k's STORE is on cycle 5k+5.
- `lb_we` is high only in STORE for k≥1:
  - first write (block 0) on cycle 10;
  - last write (block 39) on cycle 205;
  - exactly 40 writes, spaced 5 cycles apart.
- `done` is high on cycle 206 only. `busy` is high on cycles 1..206.
- Total time is 206 cycles, well inside the 800-cycle line period.
- All outputs are registered. `lb_addr` and `lb_data` are stable while `lb_we` is high.
- `start` is accepted again on cycle 207.

## Structure
- Shared package `display_pkg` holds:
  - DISPLAY_WIDTH, DISPLAY_HEIGHT, TILE_SIZE, MAP_COLS, MAP_ROWS;
  - `tam_entry_t`, a packed struct of tile index, hflip, vflip and reserved bits;
  - `pixel_row_t`, a packed 16×8-bit type.
- One sub-module, `row_align`, is combinational. It applies hflip to a word and does the 256→128 funnel shift by fine.
- The top-level FSM, counters and W_{k−1} register live in `tile_drawer`.

## Test plan
- scroll 0/0, line 0, TAM[i] = tile i, tile n row 0 = all n: block c = 16×c, 40 writes on cycles 10..205, `done` on cycle 206.
- scroll_x=5, same map: block 0 pixels 0..10 = 0, pixels 11..15 = 1. Block 39 pixels 11..15 come from col 0 (wrap): value 0.
- scroll_y=470, line 20: ey=10, tile_row 0, row 10. Then line 470 with scroll_y 470: ey=460, tile_row 28.
- hflip tile whose row is pixels 0..15 → block = 15..0. vflip with row 3 → VRAM row 12 is read (vram_a[3:0]=12).
- line_number=500 → no tam_a activity, no `lb_we`, `done` on cycle 1. `start` repeated on cycle 50 of a render → ignored, still exactly 40 writes.
- `btn_rst` low on cycle 60 → `lb_we` and `busy` drop immediately. A fresh `start` after release renders the full line.
